// File: rtl/cache_pkg.sv
// Shared definitions for the data-cache port arbiter: processor opcodes,
// store func3 encodings, arbiter FSM states and the request bundle.
package cache_pkg;

  localparam int unsigned PKG_OPCODE_W = 5;
  localparam int unsigned PKG_FUNC3_W  = 3;
  localparam int unsigned PKG_DATA_W   = 32;

  // Major opcodes as seen by the cache (instr[6:2])
  localparam logic [PKG_OPCODE_W-1:0] LOAD_opcode  = 5'b00000;
  localparam logic [PKG_OPCODE_W-1:0] STORE_opcode = 5'b01000;

  // Store widths carried in func3
  localparam logic [PKG_FUNC3_W-1:0] FUNC3_SB = 3'b000;
  localparam logic [PKG_FUNC3_W-1:0] FUNC3_SH = 3'b001;
  localparam logic [PKG_FUNC3_W-1:0] FUNC3_SW = 3'b010;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } arb_state_t;

  typedef struct packed {
    logic [PKG_OPCODE_W-1:0] opcode;
    logic [PKG_FUNC3_W-1:0]  func3;
    logic [PKG_DATA_W-1:0]   address;
    logic [PKG_DATA_W-1:0]   data;
  } cache_req_t;

endpackage

// File: rtl/cache_port_arbiter_rr.sv
// Two-requester grant logic. A lone requester always wins; on a tie the
// port other than `last` wins. Tying `last` high gives fixed priority to
// port 0, which is how the top builds CACHE_ARB_FIXED_PRIO_EN.
module rr_arbiter2 (
  input  logic [1:0] req,
  input  logic       last,
  input  logic       enable,
  output logic [1:0] gnt
);

  // Grant is purely combinational so it can be accepted in the same cycle
  always_comb begin
    gnt = 2'b00;
    if (enable) begin
      case (req)
        2'b01:   gnt = 2'b01;
        2'b10:   gnt = 2'b10;
        2'b11:   gnt = last ? 2'b01 : 2'b10;
        default: gnt = 2'b00;
      endcase
    end
  end

endmodule

// File: rtl/cache_port_arbiter.sv
// Two-port LOAD/STORE arbiter in front of the data cache. Serialises granted
// requests onto the cache start/rdy interface, holds operands for the whole
// transaction, returns load data with a one-cycle done pulse and raises a
// sticky timeout if the cache never comes back to ready.
// Build option: define CACHE_ARB_FIXED_PRIO_EN for fixed port-0 priority
// (no `last` register); otherwise ties are broken round-robin.
// TIMEOUT_CYCLES must be at least 2.
module cache_port_arbiter
  import cache_pkg::*;
#(
  parameter int unsigned OPCODE_W       = 5,
  parameter int unsigned FUNC3_W        = 3,
  parameter int unsigned DATA_W         = 32,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic [1:0]               req_i,
  input  logic [1:0][OPCODE_W-1:0] opcode_i,
  input  logic [1:0][FUNC3_W-1:0]  func3_i,
  input  logic [1:0][DATA_W-1:0]   address_i,
  input  logic [1:0][DATA_W-1:0]   data_i,
  output logic [1:0]               gnt_o,
  output logic [1:0]               done_o,
  output logic [DATA_W-1:0]        rdata_o,
  output logic                     timeout_o,
  output logic                     cache_start_o,
  output logic [OPCODE_W-1:0]      cache_opcode_o,
  output logic [FUNC3_W-1:0]       cache_func3_o,
  output logic [DATA_W-1:0]        cache_address_o,
  output logic [DATA_W-1:0]        cache_data_o,
  input  logic                     cache_rdy_i,
  input  logic [DATA_W-1:0]        cache_data_i
);

  localparam int unsigned TMO_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

  arb_state_t        state_q, state_d;
  logic              arb_en;
  logic              accept;
  logic              owner_q;
  logic              last_w;
  logic [TMO_W-1:0]  tmo_cnt_q;
  logic [TMO_W-1:0]  tmo_inc;

  rr_arbiter2 u_arb (
    .req    (req_i),
    .last   (last_w),
    .enable (arb_en),
    .gnt    (gnt_o)
  );

  assign accept  = |(req_i & gnt_o);
  assign tmo_inc = tmo_cnt_q + TMO_W'(1);

`ifdef CACHE_ARB_FIXED_PRIO_EN
  assign last_w = 1'b1;
`else
  logic last_q;

  // Remember the most recently accepted port for tie-breaking; reset value
  // makes port 0 win the first tie.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i)      last_q <= 1'b1;
    else if (accept) last_q <= gnt_o[1];
  end

  assign last_w = last_q;
`endif

  // FSM state register
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // FSM next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = ISSUE;
      ISSUE:   state_d = WAIT;
      WAIT:    if (cache_rdy_i) state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs; grants are also masked while reset is asserted so every
  // output reads 0 during reset even if requests are pending.
  always_comb begin
    arb_en        = 1'b0;
    cache_start_o = 1'b0;
    done_o        = 2'b00;
    case (state_q)
      IDLE:    arb_en = cache_rdy_i & rst_i;
      ISSUE:   cache_start_o = 1'b1;
      RESP:    done_o[owner_q] = 1'b1;
      default: ;
    endcase
  end

  // Operand registers: captured only on acceptance, so they stay put while
  // the cache reads them combinationally from ISSUE through RESP.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      owner_q         <= 1'b0;
      cache_opcode_o  <= '0;
      cache_func3_o   <= '0;
      cache_address_o <= '0;
      cache_data_o    <= '0;
    end else if (accept) begin
      owner_q         <= gnt_o[1];
      cache_opcode_o  <= opcode_i[gnt_o[1]];
      cache_func3_o   <= func3_i[gnt_o[1]];
      cache_address_o <= address_i[gnt_o[1]];
      cache_data_o    <= data_i[gnt_o[1]];
    end
  end

  // Response capture and WAIT watchdog. The flag is set on the edge where
  // the counter reaches TIMEOUT_CYCLES-1 so it is visible in that WAIT cycle.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      tmo_cnt_q <= '0;
      timeout_o <= 1'b0;
      rdata_o   <= '0;
    end else begin
      case (state_q)
        ISSUE: tmo_cnt_q <= '0;
        WAIT: begin
          if (cache_rdy_i) begin
            rdata_o <= cache_data_i;
          end else if (tmo_cnt_q != TMO_LAST) begin
            tmo_cnt_q <= tmo_inc;
            if (tmo_inc == TMO_LAST) timeout_o <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
